// File: rtl/sprite_plotter_if.sv
// Request handshake between the game-control FSM (master) and sprite_plotter (slave).
interface sprite_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_item;
  logic       req_erase;
  logic [2:0] req_pos;

  modport master (output req_valid, req_item, req_erase, req_pos, input req_ready);
  modport slave  (input req_valid, req_item, req_erase, req_pos, output req_ready);
endinterface

// File: rtl/sprite_plotter.sv
// Rasterises one garbage/press sprite per request, one pixel per clock, into vga_adapter.
// Optional outline colouring is enabled by defining PLOT_BORDER_EN.
module sprite_plotter #(
  parameter int unsigned GARB_W      = 20,
  parameter int unsigned GARB_H      = 20,
  parameter int unsigned GARB_X0     = 10,
  parameter int unsigned GARB_PITCH  = 40,
  parameter int unsigned GARB_Y0     = 8,
  parameter int unsigned PRESS_W     = 16,
  parameter int unsigned PRESS_H     = 24,
  parameter int unsigned PRESS_X0    = 2,
  parameter int unsigned PRESS_PITCH = 26,
  parameter int unsigned PRESS_Y0    = 90
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  sprite_plotter_if.slave  req,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [2:0]       colour,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, PLOT, DONE} state_t;

  state_t     state;
  logic       item_q;
  logic       erase_q;
  logic [2:0] pos_q;
  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic [7:0] w_q;
  logic [6:0] h_q;
  logic [7:0] col_q;
  logic [6:0] row_q;

  logic       in_range;
  logic [7:0] garb_org;
  logic [7:0] press_org;
  logic       last_col;
  logic       last_row;
  logic [2:0] pix_colour;

  always_comb begin
    in_range   = item_q ? (pos_q < 3'd6) : (pos_q < 3'd4);
    garb_org   = 8'(GARB_X0) + 8'(pos_q) * 8'(GARB_PITCH);
    press_org  = 8'(PRESS_X0) + 8'(pos_q) * 8'(PRESS_PITCH);
    last_col   = (col_q == w_q - 8'd1);
    last_row   = (row_q == h_q - 7'd1);
    pix_colour = item_q ? 3'b111 : 3'b010;
`ifdef PLOT_BORDER_EN
    if (col_q == '0 || last_col || row_q == '0 || last_row)
      pix_colour = 3'b100;
`endif
    if (erase_q)
      pix_colour = 3'b000;
  end

  // req_ready is held low through the done cycle and only re-raised from IDLE,
  // so the cycle after done is the first one that can accept.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      req.req_ready <= 1'b1;
      item_q        <= 1'b0;
      erase_q       <= 1'b0;
      pos_q         <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (req.req_ready && req.req_valid) begin
            item_q        <= req.req_item;
            erase_q       <= req.req_erase;
            pos_q         <= req.req_pos;
            busy          <= 1'b1;
            req.req_ready <= 1'b0;
            state         <= LOAD;
          end else begin
            busy          <= 1'b0;
            req.req_ready <= 1'b1;
          end
        end
        LOAD: begin
          x0_q  <= item_q ? press_org : garb_org;
          y0_q  <= item_q ? 7'(PRESS_Y0) : 7'(GARB_Y0);
          w_q   <= item_q ? 8'(PRESS_W) : 8'(GARB_W);
          h_q   <= item_q ? 7'(PRESS_H) : 7'(GARB_H);
          col_q <= '0;
          row_q <= '0;
          state <= in_range ? PLOT : DONE;
        end
        PLOT: begin
          x      <= x0_q + col_q;
          y      <= y0_q + row_q;
          colour <= pix_colour;
          plot   <= 1'b1;
          if (last_col) begin
            col_q <= '0;
            if (last_row)
              state <= DONE;
            else
              row_q <= row_q + 7'd1;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
        DONE: begin
          plot  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed self-checking bench for sprite_plotter: latency, pixel extents, colours, reset, back-to-back.
module tb_sprite_plotter;
  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  sprite_plotter_if rq();

  sprite_plotter dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .req      (rq),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the most recent watch()
  int w_plots, w_first_k, w_done_k, w_ndone, w_bad_c;
  int w_fx, w_fy, w_fc, w_lx, w_ly, w_minx, w_maxx, w_miny, w_maxy;
  int w_ready_after, w_busy_after;
  int q_x[3], q_y[3], q_c[3];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Presents a request and returns #1 after the accept edge (cycle 0).
  task automatic send(input logic item, input logic erase, input logic [2:0] pos);
    int guard;
    rq.req_item  = item;
    rq.req_erase = erase;
    rq.req_pos   = pos;
    rq.req_valid = 1'b1;
    guard = 0;
    while (rq.req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    rq.req_valid = 1'b0;
  endtask

  task automatic watch(input int budget, input logic [2:0] exp_c);
    w_plots = 0; w_first_k = -1; w_done_k = -1; w_ndone = 0; w_bad_c = 0;
    w_fx = -1; w_fy = -1; w_fc = -1; w_lx = -1; w_ly = -1;
    w_minx = 999; w_maxx = -1; w_miny = 999; w_maxy = -1;
    w_ready_after = -1; w_busy_after = -1;
    for (int i = 0; i < 3; i++) q_c[i] = -1;
    for (int k = 0; k < budget; k++) begin
      if (w_done_k >= 0 && k == w_done_k + 1) begin
        w_ready_after = int'(rq.req_ready);
        w_busy_after  = int'(busy);
        break;
      end
      if (plot === 1'b1) begin
        if (w_first_k < 0) begin
          w_first_k = k; w_fx = int'(x); w_fy = int'(y); w_fc = int'(colour);
        end
        w_plots++;
        w_lx = int'(x); w_ly = int'(y);
        if (int'(x) < w_minx) w_minx = int'(x);
        if (int'(x) > w_maxx) w_maxx = int'(x);
        if (int'(y) < w_miny) w_miny = int'(y);
        if (int'(y) > w_maxy) w_maxy = int'(y);
        if (colour !== exp_c) w_bad_c++;
        for (int i = 0; i < 3; i++)
          if (int'(x) == q_x[i] && int'(y) == q_y[i]) q_c[i] = int'(colour);
      end
      if (done === 1'b1) begin
        w_ndone++;
        if (w_done_k < 0) w_done_k = k;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rq.req_valid = 1'b0; rq.req_item = 1'b0; rq.req_erase = 1'b0; rq.req_pos = '0;
    tick(); tick();
    n_cmp++; if ({x, y, colour} !== 18'd0) begin n_bad++; $display("FAIL reset_xyc: got %0d,%0d,%0d want 0,0,0", x, y, colour); end
    n_cmp++; if ({plot, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got plot/busy/done %b want 000", {plot, busy, done}); end
    n_cmp++; if (rq.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rq.req_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_garbage_draw();
    send(1'b0, 1'b0, 3'd2);
    n_cmp++; if (busy !== 1'b1 || rq.req_ready !== 1'b0) begin n_bad++; $display("FAIL g_accept: got busy=%b ready=%b want 1,0", busy, rq.req_ready); end
    watch(1000, 3'b010);
    n_cmp++; if (w_first_k != 2) begin n_bad++; $display("FAIL g_first_lat: got %0d want 2", w_first_k); end
    n_cmp++; if (w_fx != 90 || w_fy != 8 || w_fc != 2) begin n_bad++; $display("FAIL g_first_px: got (%0d,%0d) c%0d want (90,8) c2", w_fx, w_fy, w_fc); end
    n_cmp++; if (w_lx != 109 || w_ly != 27) begin n_bad++; $display("FAIL g_last_px: got (%0d,%0d) want (109,27)", w_lx, w_ly); end
    n_cmp++; if (w_plots != 400) begin n_bad++; $display("FAIL g_plots: got %0d want 400", w_plots); end
    n_cmp++; if (w_bad_c != 0) begin n_bad++; $display("FAIL g_colour: got %0d wrong pixels want 0", w_bad_c); end
    n_cmp++; if (w_done_k != 402 || w_ndone != 1) begin n_bad++; $display("FAIL g_done: got k=%0d n=%0d want 402,1", w_done_k, w_ndone); end
    n_cmp++; if (w_ready_after != 1 || w_busy_after != 0) begin n_bad++; $display("FAIL g_after: got ready=%0d busy=%0d want 1,0", w_ready_after, w_busy_after); end
  endtask

  task automatic test_press_erase();
    send(1'b1, 1'b1, 3'd5);
    watch(1000, 3'b000);
    n_cmp++; if (w_minx != 132 || w_maxx != 147) begin n_bad++; $display("FAIL pe_xrange: got %0d..%0d want 132..147", w_minx, w_maxx); end
    n_cmp++; if (w_miny != 90 || w_maxy != 113) begin n_bad++; $display("FAIL pe_yrange: got %0d..%0d want 90..113", w_miny, w_maxy); end
    n_cmp++; if (w_bad_c != 0) begin n_bad++; $display("FAIL pe_colour: got %0d non-black pixels want 0", w_bad_c); end
    n_cmp++; if (w_plots != 384) begin n_bad++; $display("FAIL pe_plots: got %0d want 384", w_plots); end
    n_cmp++; if (w_done_k != 386 || w_ndone != 1) begin n_bad++; $display("FAIL pe_done: got k=%0d n=%0d want 386,1", w_done_k, w_ndone); end
  endtask

  task automatic test_out_of_range();
    send(1'b0, 1'b0, 3'd4);
    watch(50, 3'b010);
    n_cmp++; if (w_plots != 0) begin n_bad++; $display("FAIL oor_g_plots: got %0d want 0", w_plots); end
    n_cmp++; if (w_done_k != 2 || w_ready_after != 1) begin n_bad++; $display("FAIL oor_g_done: got k=%0d ready=%0d want 2,1", w_done_k, w_ready_after); end
    send(1'b1, 1'b0, 3'd6);
    watch(50, 3'b111);
    n_cmp++; if (w_plots != 0) begin n_bad++; $display("FAIL oor_p_plots: got %0d want 0", w_plots); end
    n_cmp++; if (w_done_k != 2 || w_ready_after != 1) begin n_bad++; $display("FAIL oor_p_done: got k=%0d ready=%0d want 2,1", w_done_k, w_ready_after); end
  endtask

  task automatic test_reset_mid_sprite();
    int cnt;
    int guard;
    int ndone;
    send(1'b0, 1'b0, 3'd0);
    cnt = 0; guard = 0;
    while (cnt < 100 && guard < 200) begin
      if (plot === 1'b1) cnt++;
      if (cnt < 100) tick();
      guard++;
    end
    n_cmp++; if (cnt != 100) begin n_bad++; $display("FAIL rm_reach: got %0d pixels want 100", cnt); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++; if (plot !== 1'b0 || rq.req_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_after: got plot=%b ready=%b busy=%b want 0,1,0", plot, rq.req_ready, busy); end
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1 || plot === 1'b1) ndone++;
      tick();
    end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL rm_quiet: got %0d done/plot cycles want 0", ndone); end
    send(1'b0, 1'b0, 3'd1);
    watch(1000, 3'b010);
    n_cmp++; if (w_fx != 50 || w_fy != 8 || w_plots != 400 || w_done_k != 402) begin n_bad++; $display("FAIL rm_redo: got (%0d,%0d) n=%0d done=%0d want (50,8) 400 402", w_fx, w_fy, w_plots, w_done_k); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, p2, p2x, p2y, p2c, rdy_d, rdy_d1, rdy_d2, plots;
    d1 = -1; d2 = -1; p2 = -1; p2x = -1; p2y = -1; p2c = -1; rdy_d = -1; rdy_d1 = -1; rdy_d2 = -1; plots = 0;
    send(1'b0, 1'b0, 3'd0);
    rq.req_valid = 1'b1;
    rq.req_item  = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (plot === 1'b1) begin
        plots++;
        if (d1 >= 0 && p2 < 0) begin p2 = k; p2x = int'(x); p2y = int'(y); p2c = int'(colour); end
      end
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (d1 >= 0 && k == d1)     rdy_d  = int'(rq.req_ready);
      if (d1 >= 0 && k == d1 + 1) rdy_d1 = int'(rq.req_ready);
      if (d1 >= 0 && k == d1 + 2) begin rdy_d2 = int'(rq.req_ready); rq.req_valid = 1'b0; end
      if (d2 >= 0) break;
      tick();
    end
    rq.req_valid = 1'b0;
    n_cmp++; if (d1 != 402) begin n_bad++; $display("FAIL b2b_done1: got %0d want 402", d1); end
    n_cmp++; if (rdy_d != 0 || rdy_d1 != 1 || rdy_d2 != 0) begin n_bad++; $display("FAIL b2b_ready: got %0d%0d%0d want 010", rdy_d, rdy_d1, rdy_d2); end
    n_cmp++; if (p2 != 406 || p2x != 2 || p2y != 90 || p2c != 7) begin n_bad++; $display("FAIL b2b_second: got k=%0d (%0d,%0d) c%0d want 406 (2,90) c7", p2, p2x, p2y, p2c); end
    n_cmp++; if (d2 != 790 || plots != 784) begin n_bad++; $display("FAIL b2b_done2: got k=%0d plots=%0d want 790,784", d2, plots); end
    tick(); tick();
  endtask

  task automatic test_border();
    logic [2:0] exp_edge;
    q_x[0] = 2;  q_y[0] = 90;
    q_x[1] = 17; q_y[1] = 113;
    q_x[2] = 3;  q_y[2] = 91;
`ifdef PLOT_BORDER_EN
    exp_edge = 3'b100;
`else
    exp_edge = 3'b111;
`endif
    send(1'b1, 1'b0, 3'd0);
    watch(1000, 3'b111);
    n_cmp++; if (q_c[0] != int'(exp_edge)) begin n_bad++; $display("FAIL bd_corner0: got %0d want %0d", q_c[0], exp_edge); end
    n_cmp++; if (q_c[1] != int'(exp_edge)) begin n_bad++; $display("FAIL bd_corner1: got %0d want %0d", q_c[1], exp_edge); end
    n_cmp++; if (q_c[2] != 7) begin n_bad++; $display("FAIL bd_interior: got %0d want 7", q_c[2]); end
    n_cmp++; if (w_plots != 384 || w_done_k != 386) begin n_bad++; $display("FAIL bd_timing: got n=%0d done=%0d want 384,386", w_plots, w_done_k); end
    for (int i = 0; i < 3; i++) begin q_x[i] = -1; q_y[i] = -1; end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin q_x[i] = -1; q_y[i] = -1; end
    test_reset();
    test_garbage_draw();
    test_press_erase();
    test_out_of_range();
    test_reset_mid_sprite();
    test_back_to_back();
    test_border();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
